big_mul_seq: RTL
================

# big_mul_seq

Parametrised, limb-serial unsigned big-integer multiplier for the 1024BitsLargeMultiplication module. It computes the full 2·WIDTH-bit product of two WIDTH-bit operands. It uses operand-scanning (schoolbook) on LIMB-bit limbs, one limb multiply-accumulate per cycle, with valid/ready handshakes on both sides. It is the reference datapath and check engine for the FFT-based multiplier path, and the default multiplier where latency is not critical.

## Interface
- WIDTH, 1024: operand width in bits; WIDTH % LIMB must be 0.
- LIMB, 64: limb width in bits; N = WIDTH/LIMB limbs.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operands present on In1/In2.
- in_ready  output  1  block can accept operands (IDLE only).
- In1  input  WIDTH  multiplicand A, unsigned.
- In2  input  WIDTH  multiplier B, unsigned.
- out_valid  output  1  Out holds a completed product.
- out_ready  input  1  consumer takes Out.
- Out  output  2·WIDTH  product A·B, unsigned.
- busy  output  1  high in MUL.

## Operation
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch In1→A, In2→B; clear the accumulator T (2·WIDTH bits), carry c, i and j; go to MUL.
- MUL: each cycle performs one step, with indices a_i = A limb i, b_j = B limb j, t_k = T limb k.
  - {c', t'} = t_(i+j) + a_i·b_j + c. This fits exactly in 2·LIMB bits, since the maximum is 2^(2·LIMB)−1. No overflow is possible.
  - Write t' to t_(i+j); c ← c'.
  - If j = N−1: also write c' to t_(i+N), then c←0, j←0, i←i+1.
  - Otherwise j←j+1.
  - The step with i=N−1, j=N−1 is the last: go to DONE.
- DONE:
  - out_valid=1; Out=T, stable until handshake.
  - On out_ready: go to IDLE.
  - No accept is possible in the same cycle; in_ready rises the next cycle.
- Inputs In1/In2 are don't-care outside the accept cycle. Operands are captured, so the source may change them immediately after acceptance.
- in_valid during MUL/DONE is ignored; the source must hold it until in_ready.
- out_ready outside DONE is ignored.
- Counters i and j are max(1,$clog2(N)) bits wide. N=1 is legal: a single MUL cycle.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, Out=0.
  - A, B, T, c, i and j are all 0.
- rst has priority over every handshake. Asserted mid-MUL or mid-DONE, it aborts the operation; the product is lost and nothing is emitted.
- Latency: the accept edge is E0. out_valid is high after edge E_(N·N), exactly N·N cycles later (256 for the defaults).
- Throughput: one product per N·N+2 cycles with out_ready held high: N·N MUL cycles, 1 DONE cycle and 1 IDLE cycle.
- Out is registered and changes only on the transition into DONE or on reset.
- in_ready and out_valid are registered, decoded from state.

## Structure
- Package big_mul_pkg holds:
  - state enum: IDLE, MUL, DONE.
  - function limb_count(WIDTH, LIMB).
  - elaboration-time check that WIDTH % LIMB == 0 (fatal otherwise).
- Sub-module limb_mac:
  - combinational; inputs a, b, t, c (LIMB each); output {hi, lo} (2·LIMB).
  - It is the only multiplier instance and the unit later shared with the FFT carry-resolution stage.
- Top holds the FSM, counters, limb-indexed T writes and the handshake.

## Test plan
- WIDTH=16, LIMB=4, In1=0xFFFF, In2=0xFFFF → Out=0xFFFE0001; out_valid exactly 16 cycles after accept.
- Defaults, In1=In2=2^1024−1 → Out=2^2048−2^1025+1; out_valid at cycle 256; busy high for cycles 1..256.
- Defaults, In1=0, In2=random → Out=0. In1=1, In2=X → Out=X (zero-extended).
- Backpressure: out_ready low for 10 cycles in DONE → Out and out_valid stable, in_ready=0 throughout. Then out_ready=1 → IDLE the next cycle; a second operand pair is accepted one cycle later.
- rst asserted at MUL cycle 100, then a new pair 3×5 presented → all outputs return to reset values the next cycle; the new product Out=15 arrives with no residue from the aborted run.
- N=1 (WIDTH=LIMB=8), 0xFF·0xFF → Out=0xFE01 one cycle after accept.

Source files
------------

// File: rtl/big_mul_pkg.sv
// big_mul_pkg: shared types and elaboration helpers for the limb-serial
// big-integer multiplier.
//   state_t     : FSM encoding (IDLE, MUL, DONE)
//   limb_count  : number of LIMB-bit limbs in a WIDTH-bit operand
//   limbs_fit   : operand width is a whole number of limbs; the top stops
//                 elaboration with $fatal when this is false
package big_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int limb_count(input int width, input int limb);
    return width / limb;
  endfunction

  function automatic bit limbs_fit(input int width, input int limb);
    return (limb > 0) && (width >= limb) && ((width % limb) == 0);
  endfunction

endpackage

// File: rtl/limb_mac.sv
// limb_mac: combinational limb multiply-accumulate, {hi, lo} = a*b + t + c.
// The worst case (2^L-1)^2 + 2*(2^L-1) = 2^(2L)-1, so the 2*LIMB-bit result
// never overflows.
// Ports:
//   a, b : limb operands           (LIMB)
//   t    : accumulator limb        (LIMB)
//   c    : incoming carry limb     (LIMB)
//   hi   : outgoing carry limb     (LIMB)
//   lo   : new accumulator limb    (LIMB)
module limb_mac #(
  parameter int LIMB = 64
) (
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic [LIMB-1:0] t,
  input  logic [LIMB-1:0] c,
  output logic [LIMB-1:0] hi,
  output logic [LIMB-1:0] lo
);

  logic [2*LIMB-1:0] prod;
  logic [2*LIMB-1:0] sum;

  assign prod     = {{LIMB{1'b0}}, a} * {{LIMB{1'b0}}, b};
  assign sum      = prod + {{LIMB{1'b0}}, t} + {{LIMB{1'b0}}, c};
  assign {hi, lo} = sum;

endmodule

// File: rtl/big_mul_seq.sv
// big_mul_seq: limb-serial schoolbook multiplier, one limb MAC per cycle.
// Computes the full 2*WIDTH-bit unsigned product in N*N MUL cycles
// (N = WIDTH/LIMB).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   In1, In2            : operands A and B (WIDTH), captured on accept
//   out_valid/out_ready : result handshake (valid only in DONE)
//   Out                 : product (2*WIDTH), registered, stable in DONE
//   busy                : high while in MUL
module big_mul_seq
  import big_mul_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int LIMB  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   In1,
  input  logic [WIDTH-1:0]   In2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Out,
  output logic               busy
);

  localparam int N  = limb_count(WIDTH, LIMB);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (!limbs_fit(WIDTH, LIMB)) begin : g_width_chk
    $fatal(1, "big_mul_seq: WIDTH must be a non-zero multiple of LIMB");
  end

  state_t             state;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [2*WIDTH-1:0] t_r, t_nxt, out_r;
  logic [LIMB-1:0]    c_r;
  logic [IW-1:0]      i_r, j_r;

  logic [LIMB-1:0]    a_limb, b_limb, t_limb, mac_hi, mac_lo;
  logic [IW:0]        k_lo, k_hi;
  logic               last_j, last_i;

  // k_lo = i+j receives the low limb; k_hi = i+N receives the row carry.
  // Both are below 2N, so IW+1 bits suffice.
  assign k_lo   = {1'b0, i_r} + {1'b0, j_r};
  assign k_hi   = {1'b0, i_r} + (IW+1)'(N);
  assign last_j = (j_r == IW'(N-1));
  assign last_i = (i_r == IW'(N-1));

  assign a_limb = a_r[i_r*LIMB +: LIMB];
  assign b_limb = b_r[j_r*LIMB +: LIMB];
  assign t_limb = t_r[k_lo*LIMB +: LIMB];

  limb_mac #(.LIMB(LIMB)) u_mac (
    .a  (a_limb),
    .b  (b_limb),
    .t  (t_limb),
    .c  (c_r),
    .hi (mac_hi),
    .lo (mac_lo)
  );

  // Accumulator after the current step. At the end of a row the carry
  // lands in limb i+N, which no earlier step of this row has touched.
  always_comb begin
    t_nxt = t_r;
    t_nxt[k_lo*LIMB +: LIMB] = mac_lo;
    if (last_j) t_nxt[k_hi*LIMB +: LIMB] = mac_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      t_r       <= '0;
      c_r       <= '0;
      i_r       <= '0;
      j_r       <= '0;
      out_r     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= In1;
            b_r      <= In2;
            t_r      <= '0;
            c_r      <= '0;
            i_r      <= '0;
            j_r      <= '0;
            state    <= MUL;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MUL: begin
          t_r <= t_nxt;
          if (last_j) begin
            c_r <= '0;
            j_r <= '0;
            if (last_i) begin
              // Out samples the final accumulator directly so it is valid
              // on the same edge that raises out_valid.
              out_r     <= t_nxt;
              state     <= DONE;
              out_valid <= 1'b1;
              busy      <= 1'b0;
            end else begin
              i_r <= i_r + 1'b1;
            end
          end else begin
            c_r <= mac_hi;
            j_r <= j_r + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign Out = out_r;

endmodule
